// File: rtl/ppu_pkg.sv
// Shared types for the PPU frame-synchronous write queue.
package ppu_pkg;

    // Avalon word-address region select, address[9:8].
    typedef enum logic [1:0] {
        REG_ATTR   = 2'b00,
        REG_SPRITE = 2'b01,
        REG_COLOR  = 2'b10,
        REG_CTRL   = 2'b11
    } region_e;

    // First vertical-blank line.
    localparam int unsigned VACTIVE = 480;

    // Commit sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        DRAIN = 2'b10
    } commit_state_e;

    // One queued table write.
    typedef struct packed {
        logic [15:0] address;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/ppu_write_queue_sync_fifo.sv
// Synchronous FIFO with occupancy count; reset flushes the pointers.
module sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Control registers with asynchronous flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care once pointers are flushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ppu_write_queue.sv
// Frame-synchronous table-write buffer: queues CPU writes to the attribute,
// sprite and colour tables and replays a snapshot of them during vblank
// when software arms a commit through the control region.
module ppu_write_queue
    import ppu_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned VACTIVE = ppu_pkg::VACTIVE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [15:0]              address,
    input  logic [31:0]              writedata,
    output logic                     waitrequest,
    input  logic [9:0]               vcount,
    output logic [2:0]               mem_write,
    output logic [15:0]              w_addr,
    output logic [31:0]              w_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     commit_done
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = $bits(entry_t);

    commit_state_e state_q, state_d;
    logic [LW-1:0] remain_q, remain_d;
    logic          pending_q, pending_d;
    logic [2:0]    mem_write_q, mem_write_d;
    logic [15:0]   w_addr_q, w_addr_d;
    logic [31:0]   w_data_q, w_data_d;
    logic          commit_done_q, commit_done_d;

    logic          is_ctrl, table_req, push, pop, arm, vblank;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [EW-1:0] fifo_rd;
    entry_t        wr_entry, head;

    assign is_ctrl     = (address[9:8] == REG_CTRL);
    assign table_req   = chipselect && write && !is_ctrl;
    assign push        = table_req && !fifo_full;
    assign waitrequest = table_req && fifo_full;
    assign arm         = chipselect && write && is_ctrl && writedata[0];
    assign vblank      = (vcount >= 10'(VACTIVE));

    assign wr_entry.address = address;
    assign wr_entry.data    = writedata;
    assign head             = entry_t'(fifo_rd);

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign level       = fifo_level;
    assign mem_write   = mem_write_q;
    assign w_addr      = w_addr_q;
    assign w_data      = w_data_q;
    assign commit_done = commit_done_q;

    // Commit sequencing, snapshot countdown and table-write port next values.
    // commit_done is registered so it lands the cycle after the last write.
    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        pending_d     = pending_q;
        commit_done_d = 1'b0;
        pop           = 1'b0;
        mem_write_d   = '0;
        w_addr_d      = w_addr_q;
        w_data_d      = w_data_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = ARMED;
                    remain_d = fifo_level;
                end
            end
            ARMED: begin
                if (arm) begin
                    pending_d = 1'b1;
                end
                if (vblank) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (remain_q == '0) begin
                    commit_done_d = 1'b1;
                    pending_d     = 1'b0;
                    if (pending_q || arm) begin
                        state_d  = ARMED;
                        remain_d = fifo_level;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (arm) begin
                        pending_d = 1'b1;
                    end
                    if (vblank && !fifo_empty) begin
                        pop      = 1'b1;
                        remain_d = remain_q - LW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            mem_write_d = 3'b001 << head.address[9:8];
            w_addr_d    = head.address;
            w_data_d    = head.data;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            remain_q      <= '0;
            pending_q     <= 1'b0;
            mem_write_q   <= '0;
            w_addr_q      <= '0;
            w_data_q      <= '0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            pending_q     <= pending_d;
            mem_write_q   <= mem_write_d;
            w_addr_q      <= w_addr_d;
            w_data_q      <= w_data_d;
            commit_done_q <= commit_done_d;
        end
    end

endmodule

// File: tb/tb_ppu_write_queue.sv
// Self-checking bench for ppu_write_queue: an in-order expected-write queue
// plus a pushed-minus-committed occupancy count.
module tb_ppu_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [9:0]  vcount;
    logic [2:0]  mem_write;
    logic [15:0] w_addr;
    logic [31:0] w_data;
    logic [5:0]  level;
    logic        commit_done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned writes_seen = 0;
    int unsigned done_seen   = 0;
    int unsigned model_level = 0;
    longint      cyc = 0;
    longint      win_first = -1;
    longint      win_last  = -1;
    logic [47:0] exp_q [$];
    logic [47:0] mon_e;

    ppu_write_queue #(
        .DEPTH   (32),
        .VACTIVE (480)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .vcount      (vcount),
        .mem_write   (mem_write),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .level       (level),
        .commit_done (commit_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Every table write must match the oldest committed-but-unseen push.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write != 3'b000) begin
                writes_seen++;
                if (win_first < 0) win_first = cyc;
                win_last = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_write", {61'd0, mem_write}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("wr_en",   mem_write, 3'b001 << mon_e[41:40]);
                    check_eq("wr_addr", w_addr, mon_e[47:32]);
                    check_eq("wr_data", w_data, mon_e[31:0]);
                end
            end
            if (commit_done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        int unsigned n = 0;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        #0;
        while (waitrequest && n < 200) begin
            tick();
            n++;
        end
        if (waitrequest) check_eq("wr_stall_timeout", 1, 0);
        else if (a[9:8] != 2'b11) begin
            exp_q.push_back({a, d});
            model_level++;
        end
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    // region 3 selects a random table region.
    task automatic push_rand(input int unsigned n, input int unsigned region);
        logic [31:0] t;
        logic [15:0] a;
        logic [1:0]  r;
        for (int i = 0; i < int'(n); i++) begin
            t = $urandom;
            a = t[15:0];
            r = (region > 2) ? 2'($urandom_range(0, 2)) : 2'(region);
            a[9:8] = r;
            bus_wr(a, $urandom);
        end
    endtask

    task automatic arm_commit(input logic bit0);
        logic [31:0] t;
        logic [15:0] a;
        logic [31:0] d;
        t = $urandom;
        a = t[15:0];
        a[9:8] = 2'b11;
        d = $urandom;
        d[0] = bit0;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        #1;
        check_eq("ctrl_waitrequest", waitrequest, 0);
        bus_wr(a, d);
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (!commit_done && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, commit_done, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; chipselect = 1'b0; write = 1'b0;
        tick(); tick();
        exp_q.delete();
        model_level = 0;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int unsigned wb, db, k, snap, n;
        logic [31:0] t;
        logic [15:0] a;
        logic [31:0] d;

        reset = 1'b1; chipselect = 1'b0; write = 1'b0;
        address = '0; writedata = '0; vcount = 10'd0;
        #1;
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_w_addr", w_addr, 0);
        check_eq("rst_w_data", w_data, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_commit_done", commit_done, 0);
        check_eq("rst_waitrequest", waitrequest, 0);
        do_reset();

        // Single attr write committed at vblank start.
        vcount = 10'd100;
        bus_wr(16'h0003, 32'h1234_5678);
        check_eq("t1_level", level, 1);
        arm_commit(1'b1);
        wb = writes_seen;
        repeat (20) tick();
        check_eq("t1_no_early_write", writes_seen - wb, 0);
        vcount = 10'd480;
        tick();
        check_eq("t1_armed_no_write", mem_write, 0);
        tick();
        check_eq("t1_mem_write", mem_write, 3'b001);
        check_eq("t1_w_addr", w_addr, 16'h0003);
        check_eq("t1_w_data", w_data, 32'h1234_5678);
        check_eq("t1_done_not_yet", commit_done, 0);
        tick();
        check_eq("t1_write_one_cycle", mem_write, 0);
        check_eq("t1_done", commit_done, 1);
        tick();
        check_eq("t1_done_pulse", commit_done, 0);
        check_eq("t1_level_after", level, 0);

        // Control write with bit0 clear must not arm.
        do_reset();
        vcount = 10'd100;
        push_rand(2, 3);
        arm_commit(1'b0);
        vcount = 10'd480;
        wb = writes_seen;
        repeat (20) tick();
        check_eq("ctrl_bit0_clear_writes", writes_seen - wb, 0);
        check_eq("ctrl_bit0_clear_level", level, 2);

        // Full queue backpressure; arm still accepted; 32 back-to-back writes.
        do_reset();
        vcount = 10'd100;
        push_rand(32, 1);
        check_eq("t2_level_full", level, 32);
        t = $urandom; a = t[15:0]; a[9:8] = 2'b01; d = $urandom;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        #1;
        check_eq("t2_waitrequest_full", waitrequest, 1);
        check_eq("t2_level_held", level, 32);
        chipselect = 1'b0; write = 1'b0;
        tick();
        arm_commit(1'b1);
        wb = writes_seen; win_first = -1; win_last = -1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        vcount = 10'd480;
        n = 0;
        #0;
        while (waitrequest && n < 100) begin
            tick();
            n++;
        end
        check_eq("t2_stall_release", waitrequest, 0);
        check_eq("t2_stall_cycles", n, 2);
        exp_q.push_back({a, d});
        model_level++;
        tick();
        chipselect = 1'b0; write = 1'b0;
        wait_done("t2_done_timeout", 200);
        check_eq("t2_writes", writes_seen - wb, 32);
        check_eq("t2_consecutive", win_last - win_first + 1, 32);
        check_eq("t2_level_left", level, 1);

        // Snapshot excludes later pushes; re-arm in DRAIN commits the rest.
        do_reset();
        vcount = 10'd100;
        push_rand(3, 3);
        arm_commit(1'b1);
        push_rand(2, 3);
        check_eq("t3_level5", level, 5);
        wb = writes_seen; db = done_seen;
        vcount = 10'd480;
        tick();
        arm_commit(1'b1);
        wait_done("t3_done1_timeout", 100);
        vcount = 10'd0;
        check_eq("t3_writes1", writes_seen - wb, 3);
        check_eq("t3_level2", level, 2);
        repeat (20) tick();
        check_eq("t3_no_write_outside_vblank", writes_seen - wb, 3);
        vcount = 10'd480;
        wait_done("t3_done2_timeout", 100);
        tick();
        check_eq("t3_writes2", writes_seen - wb, 5);
        check_eq("t3_done_count", done_seen - db, 2);
        check_eq("t3_level0", level, 0);

        // Vblank ends mid-drain: pause, then resume in order.
        do_reset();
        vcount = 10'd100;
        push_rand(6, 3);
        vcount = 10'd524;
        arm_commit(1'b1);
        wb = writes_seen; db = done_seen;
        tick(); tick(); tick();
        vcount = 10'd0;
        repeat (20) tick();
        check_eq("t4_paused_writes", writes_seen - wb, 2);
        check_eq("t4_no_done_paused", done_seen - db, 0);
        check_eq("t4_level_paused", level, 4);
        vcount = 10'd480;
        wait_done("t4_done_timeout", 100);
        tick();
        check_eq("t4_writes_total", writes_seen - wb, 6);
        check_eq("t4_single_done", done_seen - db, 1);

        // Empty commit: done on the second vblank edge, no writes.
        do_reset();
        vcount = 10'd100;
        arm_commit(1'b1);
        wb = writes_seen;
        repeat (5) tick();
        vcount = 10'd480;
        tick();
        check_eq("t5_done_early", commit_done, 0);
        tick();
        check_eq("t5_done", commit_done, 1);
        check_eq("t5_mem_write", mem_write, 0);
        tick();
        check_eq("t5_done_pulse", commit_done, 0);
        check_eq("t5_writes", writes_seen - wb, 0);

        // Reset mid-drain flushes everything.
        do_reset();
        vcount = 10'd100;
        push_rand(8, 3);
        arm_commit(1'b1);
        vcount = 10'd480;
        tick(); tick(); tick(); tick();
        check_eq("t6_level_mid", level, 5);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_mem_write", mem_write, 0);
        check_eq("t6_rst_w_addr", w_addr, 0);
        check_eq("t6_rst_w_data", w_data, 0);
        check_eq("t6_rst_level", level, 0);
        check_eq("t6_rst_done", commit_done, 0);
        exp_q.delete();
        model_level = 0;
        tick(); tick();
        reset = 1'b0;
        wb = writes_seen; db = done_seen;
        repeat (40) tick();
        check_eq("t6_no_writes_after", writes_seen - wb, 0);
        check_eq("t6_no_done_after", done_seen - db, 0);
        check_eq("t6_level_after", level, 0);

        // Randomized rounds with leftovers carried between commits.
        vcount = 10'd100;
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(0, 8);
            push_rand(k, 3);
            snap = model_level;
            arm_commit(1'b1);
            push_rand($urandom_range(0, 3), 3);
            wb = writes_seen;
            vcount = 10'd480;
            wait_done("rnd_done_timeout", 100);
            vcount = 10'd100;
            tick();
            check_eq("rnd_writes", writes_seen - wb, snap);
            model_level = model_level - snap;
            check_eq("rnd_level", level, model_level);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
